// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus crossbar: FSM states, byte-select width
// and default widths.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ERR  = 2'd3
   } bus_state_e;

   localparam int BYTE_SEL_W = 4;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_SEL_W  = 3;

   // Index width that stays legal for a single-entry vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner and
// wraps, so that winner moves to the lowest priority.
module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int  cand;
      logic found;
      cand  = 0;
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(last) + off) % N;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/bus_xbar_rr.sv
// Shared-bus interconnect: round-robin master arbitration, address-field slave decode,
// and an error response on decode miss or slave timeout.
//
// state   | meaning
// IDLE    | no owner; arbitrate among requesting masters
// OWN     | master granted; waiting for its address strobe
// WAIT    | slave selected; waiting for s_ready or timeout
// ERR     | one-cycle error response for a decode miss
module bus_xbar_rr
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 5,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SEL_W       = DEF_SEL_W,
   parameter int TIMEOUT     = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_req,
   input  logic [NUM_MASTERS-1:0]            m_as,
   input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
   input  logic [NUM_MASTERS-1:0]            m_we,
   input  logic [NUM_MASTERS*BYTE_SEL_W-1:0] m_sel,
   output logic [NUM_MASTERS-1:0]            m_grant,
   output logic [NUM_MASTERS-1:0]            m_ready,
   output logic [NUM_MASTERS-1:0]            m_err,
   output logic [DATA_W-1:0]                 m_rdata,
   output logic [NUM_SLAVES-1:0]             s_ce,
   output logic                              s_as,
   output logic [ADDR_W-1:0]                 s_addr,
   output logic [DATA_W-1:0]                 s_wdata,
   output logic                              s_we,
   output logic [BYTE_SEL_W-1:0]             s_sel,
   input  logic [NUM_SLAVES*DATA_W-1:0]      s_rdata,
   input  logic [NUM_SLAVES-1:0]             s_ready
);

   localparam int MW = idx_w(NUM_MASTERS);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   bus_state_e               state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [MW-1:0]            last_q, last_d;
   logic [SEL_W-1:0]         idx_q, idx_d;
   logic [TW-1:0]            tmo_q, tmo_d;

   logic [NUM_MASTERS-1:0]   arb_gnt;
   logic [MW-1:0]            arb_idx;

   logic                     g_req, g_as, g_we;
   logic [ADDR_W-1:0]        g_addr;
   logic [DATA_W-1:0]        g_wdata;
   logic [BYTE_SEL_W-1:0]    g_sel;
   logic [SEL_W-1:0]         addr_idx;
   logic                     addr_hit;
   logic [DATA_W-1:0]        sel_rdata;
   logic                     sel_ready;
   logic                     tmo_hit;
   logic                     ce_on;
   logic [SEL_W-1:0]         ce_sel;

   bus_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
      .req  (m_req),
      .last (last_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // One-hot grant drives an AND-OR mux of the owning master's fields.
   always_comb begin
      g_req   = |(m_req & grant_q);
      g_as    = |(m_as & grant_q);
      g_we    = |(m_we & grant_q);
      g_addr  = '0;
      g_wdata = '0;
      g_sel   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            g_addr  = m_addr[i*ADDR_W +: ADDR_W];
            g_wdata = m_wdata[i*DATA_W +: DATA_W];
            g_sel   = m_sel[i*BYTE_SEL_W +: BYTE_SEL_W];
         end
      end
   end

   assign addr_idx = g_addr[ADDR_W-1 -: SEL_W];
   assign addr_hit = (32'(addr_idx) < 32'(NUM_SLAVES));
   assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT));

   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (idx_q == SEL_W'(s)) begin
            sel_rdata = s_rdata[s*DATA_W +: DATA_W];
            sel_ready = s_ready[s];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      idx_d   = idx_q;
      tmo_d   = '0;
      ce_on   = 1'b0;
      ce_sel  = idx_q;
      s_as    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_we    = 1'b0;
      s_sel   = '0;
      m_ready = '0;
      m_err   = '0;
      m_rdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (|m_req) begin
               grant_d = arb_gnt;
               last_d  = arb_idx;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            s_as    = g_as;
            s_addr  = g_addr;
            s_wdata = g_wdata;
            s_we    = g_we;
            s_sel   = g_sel;
            if (g_as) begin
               if (addr_hit) begin
                  idx_d   = addr_idx;
                  ce_on   = 1'b1;
                  ce_sel  = addr_idx;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_ERR;
               end
            end else if (!g_req) begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            s_addr  = g_addr;
            s_wdata = g_wdata;
            s_we    = g_we;
            s_sel   = g_sel;
            // s_ready is checked before the timeout so a same-cycle reply is not lost.
            if (sel_ready) begin
               ce_on   = 1'b1;
               m_ready = grant_q;
               m_rdata = sel_rdata;
               grant_d = '0;
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               m_ready = grant_q;
               m_err   = grant_q;
               grant_d = '0;
               state_d = ST_IDLE;
            end else begin
               ce_on   = 1'b1;
               m_rdata = sel_rdata;
               if (TIMEOUT != 0) tmo_d = tmo_q + 1'b1;
            end
         end
         ST_ERR: begin
            m_ready = grant_q;
            m_err   = grant_q;
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ce = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         s_ce[s] = ce_on && (ce_sel == SEL_W'(s));
      end
   end

   assign m_grant = grant_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= MW'(NUM_MASTERS - 1);
         idx_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Directed bench for bus_xbar_rr: 2 masters, 5 slaves, TIMEOUT=8; the bench plays the
// slaves and checks against hand-computed values.
module tb_bus_xbar_rr;

   localparam int NM = 2;
   localparam int NS = 5;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NM-1:0]     m_req = '0;
   logic [NM-1:0]     m_as = '0;
   logic [NM*AW-1:0]  m_addr = '0;
   logic [NM*DW-1:0]  m_wdata = '0;
   logic [NM-1:0]     m_we = '0;
   logic [NM*4-1:0]   m_sel = '0;
   logic [NM-1:0]     m_grant, m_ready, m_err;
   logic [DW-1:0]     m_rdata;
   logic [NS-1:0]     s_ce;
   logic              s_as, s_we;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic [3:0]        s_sel;
   logic [NS*DW-1:0]  s_rdata = '0;
   logic [NS-1:0]     s_ready = '0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bus_xbar_rr #(
      .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
      .SEL_W(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_as(m_as), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_we(m_we), .m_sel(m_sel),
      .m_grant(m_grant), .m_ready(m_ready), .m_err(m_err), .m_rdata(m_rdata),
      .s_ce(s_ce), .s_as(s_as), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_we(s_we), .s_sel(s_sel), .s_rdata(s_rdata), .s_ready(s_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns the first non-zero grant seen at a negedge; zero if none within 10 cycles.
   task automatic wait_grant(output logic [NM-1:0] g);
      g = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         if (m_grant != '0) begin
            g = m_grant;
            break;
         end
      end
   endtask

   // Called during OWN: strobe, then slave s answers in the first WAIT cycle.
   task automatic strobe_and_finish(input string tag, input int m, input int s,
                                    input logic [DW-1:0] data, input logic [NM-1:0] exp_g);
      m_as[m] = 1'b1;
      #1;
      chk({tag, "_ce"}, 64'(s_ce), 64'(1) << s);
      @(negedge clk);
      m_as = '0;
      s_rdata[s*DW +: DW] = data;
      s_ready[s] = 1'b1;
      #1;
      chk({tag, "_ready"}, 64'(m_ready), 64'(exp_g));
      chk({tag, "_rdata"}, 64'(m_rdata), 64'(data));
      chk({tag, "_err"},   64'(m_err),   64'd0);
      @(negedge clk);
      s_ready = '0;
      #1;
   endtask

   initial begin
      logic [NM-1:0] g;
      int m;

      // Reset state
      #2;
      chk("rst_grant", 64'(m_grant), 64'd0);
      chk("rst_ready", 64'(m_ready), 64'd0);
      chk("rst_ce",    64'(s_ce),    64'd0);
      chk("rst_as",    64'(s_as),    64'd0);

      // Master 0 reads slave 0, ready in the third WAIT cycle
      @(negedge clk);
      rst = 1'b1;
      m_req = 2'b01;
      m_addr[31:0] = 32'h0000_0010;
      m_sel[3:0] = 4'hF;
      #1;
      chk("t1_grant_idle", 64'(m_grant), 64'd0);
      @(negedge clk); #1;
      chk("t1_grant", 64'(m_grant), 64'b01);
      m_as[0] = 1'b1;
      #1;
      chk("t1_ce",    64'(s_ce),   64'b00001);
      chk("t1_as",    64'(s_as),   64'd1);
      chk("t1_addr",  64'(s_addr), 64'h10);
      @(negedge clk);
      m_as = '0;
      s_rdata[31:0] = 32'hDEAD_BEEF;
      #1;
      chk("t1_w1_ready", 64'(m_ready), 64'd0);
      chk("t1_w1_ce",    64'(s_ce),    64'b00001);
      chk("t1_w1_as",    64'(s_as),    64'd0);
      @(negedge clk); #1;
      chk("t1_w2_ready", 64'(m_ready), 64'd0);
      @(negedge clk);
      s_ready[0] = 1'b1;
      m_req = '0;
      #1;
      chk("t1_ready", 64'(m_ready), 64'b01);
      chk("t1_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
      chk("t1_err",   64'(m_err),   64'd0);
      @(negedge clk);
      s_ready = '0;
      #1;
      chk("t1_release", 64'(m_grant), 64'd0);
      chk("t1_rdata0",  64'(m_rdata), 64'd0);

      // Request withdrawn before the strobe: no slave access
      m_req = 2'b01;
      wait_grant(g);
      chk("drop_grant", 64'(g), 64'b01);
      m_req = '0;
      #1;
      chk("drop_ce_own", 64'(s_ce), 64'd0);
      @(negedge clk); #1;
      chk("drop_release", 64'(m_grant), 64'd0);
      chk("drop_ce",      64'(s_ce),    64'd0);

      // Fresh reset, then both masters request continuously
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_addr[31:0]  = 32'h0000_0100;
      m_addr[63:32] = 32'h2000_0000;
      m_req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_grant(g);
         chk($sformatf("rr_grant_%0d", t), 64'(g), (t % 2 == 0) ? 64'b01 : 64'b10);
         m = g[1] ? 1 : 0;
         strobe_and_finish($sformatf("rr_%0d", t), m, m, 32'h1000_0000 + 32'(t), g);
      end

      // Master 1 writes to an unmapped slave index
      m_req = 2'b10;
      m_addr[63:32] = 32'hE000_0000;
      m_we[1] = 1'b1;
      m_wdata[63:32] = 32'h5555_AAAA;
      wait_grant(g);
      chk("dec_grant", 64'(g), 64'b10);
      m_as[1] = 1'b1;
      #1;
      chk("dec_ce_own",    64'(s_ce),    64'd0);
      chk("dec_we",        64'(s_we),    64'd1);
      chk("dec_wdata",     64'(s_wdata), 64'h5555_AAAA);
      chk("dec_ready_own", 64'(m_ready), 64'd0);
      @(negedge clk);
      m_as = '0;
      m_req = '0;
      m_we = '0;
      #1;
      chk("dec_ready", 64'(m_ready), 64'b10);
      chk("dec_err",   64'(m_err),   64'b10);
      chk("dec_rdata", 64'(m_rdata), 64'd0);
      chk("dec_ce",    64'(s_ce),    64'd0);
      @(negedge clk); #1;
      chk("dec_ready_after", 64'(m_ready), 64'd0);
      chk("dec_grant_after", 64'(m_grant), 64'd0);

      // Slave 2 never answers; a stray ready from slave 0 must be ignored
      m_req = 2'b01;
      m_addr[31:0] = 32'h4000_0000;
      wait_grant(g);
      chk("tmo_grant", 64'(g), 64'b01);
      m_as[0] = 1'b1;
      #1;
      chk("tmo_ce_own", 64'(s_ce), 64'b00100);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         m_as = '0;
         s_ready = (k == 3) ? 5'b00001 : 5'b00000;
         #1;
         chk($sformatf("tmo_wait_ready_%0d", k), 64'(m_ready), 64'd0);
         chk($sformatf("tmo_wait_ce_%0d", k),    64'(s_ce),    64'b00100);
      end
      @(negedge clk);
      s_ready = '0;
      m_addr[31:0] = 32'h0000_0010;
      #1;
      chk("tmo_ready", 64'(m_ready), 64'b01);
      chk("tmo_err",   64'(m_err),   64'b01);
      chk("tmo_ce",    64'(s_ce),    64'd0);
      chk("tmo_rdata", 64'(m_rdata), 64'd0);
      wait_grant(g);
      chk("tmo_next_grant", 64'(g), 64'b01);
      strobe_and_finish("tmo_next", 0, 0, 32'hCAFE_F00D, 2'b01);
      m_req = '0;

      // Slave 3 answers on the very cycle the timeout expires
      m_req = 2'b10;
      m_addr[63:32] = 32'h6000_0000;
      s_rdata[3*DW +: DW] = 32'h1234_5678;
      wait_grant(g);
      chk("race_grant", 64'(g), 64'b10);
      m_as[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         m_as = '0;
      end
      @(negedge clk);
      s_ready[3] = 1'b1;
      m_req = '0;
      #1;
      chk("race_ready", 64'(m_ready), 64'b10);
      chk("race_err",   64'(m_err),   64'd0);
      chk("race_rdata", 64'(m_rdata), 64'h1234_5678);
      @(negedge clk);
      s_ready = '0;

      // Async reset in the middle of a WAIT
      m_req = 2'b01;
      m_addr[31:0] = 32'h2000_0000;
      wait_grant(g);
      chk("arst_grant", 64'(g), 64'b01);
      m_as[0] = 1'b1;
      @(negedge clk);
      m_as = '0;
      #1;
      chk("arst_ce_wait", 64'(s_ce), 64'b00010);
      rst = 1'b0;
      #1;
      chk("arst_ce",    64'(s_ce),    64'd0);
      chk("arst_grant0", 64'(m_grant), 64'd0);
      chk("arst_ready", 64'(m_ready), 64'd0);
      chk("arst_addr",  64'(s_addr),  64'd0);
      @(negedge clk);
      rst = 1'b1;
      m_req = 2'b11;
      wait_grant(g);
      chk("arst_first", 64'(g), 64'b01);
      strobe_and_finish("arst_txn", 0, 1, 32'h0BAD_F00D, 2'b01);
      m_req = '0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
